// File: rtl/shift_sequencer.sv
// Multi-cycle RV32I shift unit (SLL/SRL/SRA) stepping a small shift stage per clock.
// Optional build macro SHIFTSEQ_STEP4_EN: steps by 4 while at least 4 positions remain.
module shift_sequencer #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rd_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             state_reg, state_next;
    logic [XLEN-1:0]    data_reg, data_next;
    logic [XLEN-1:0]    rd_reg, rd_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic [1:0]         op_reg, op_next;

    logic [SHAMT_W-1:0] shamt_in;
    logic               unused_rs2;
    logic               shift_right;
    logic               fill;
    logic [XLEN-1:0]    left1, right1;
    logic [XLEN-1:0]    stepped;
    logic [SHAMT_W-1:0] step_amt;

    assign shamt_in   = rs2_i[SHAMT_W-1:0];
    assign unused_rs2 = ^rs2_i[XLEN-1:SHAMT_W];

    // Reserved op 11 falls through to a left shift.
    assign shift_right = (op_reg == OP_SRL) || (op_reg == OP_SRA);
    assign fill        = (op_reg == OP_SRA) ? data_reg[XLEN-1] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_step1
            if (gi == 0) begin : g_l0
                assign left1[gi] = 1'b0;
            end else begin : g_l
                assign left1[gi] = data_reg[gi-1];
            end
            if (gi == XLEN-1) begin : g_rtop
                assign right1[gi] = fill;
            end else begin : g_r
                assign right1[gi] = data_reg[gi+1];
            end
        end
    endgenerate

`ifdef SHIFTSEQ_STEP4_EN
    logic [XLEN-1:0] left4, right4;
    logic            use_step4;

    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_step4
            if (gi < 4) begin : g_l0
                assign left4[gi] = 1'b0;
            end else begin : g_l
                assign left4[gi] = data_reg[gi-4];
            end
            if (gi > XLEN-5) begin : g_rtop
                assign right4[gi] = fill;
            end else begin : g_r
                assign right4[gi] = data_reg[gi+4];
            end
        end
    endgenerate

    assign use_step4 = (count_reg >= SHAMT_W'(4));
    assign step_amt  = use_step4 ? SHAMT_W'(4) : SHAMT_W'(1);
    assign stepped   = use_step4 ? (shift_right ? right4 : left4)
                                 : (shift_right ? right1 : left1);
`else
    assign step_amt  = SHAMT_W'(1);
    assign stepped   = shift_right ? right1 : left1;
`endif

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rd_next    = rd_reg;
        count_next = count_reg;
        op_next    = op_reg;
        // A flush wins over everything, including a request in the same cycle.
        if (kill_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        data_next  = rs1_i;
                        count_next = shamt_in;
                        op_next    = op_i;
                        if (shamt_in == '0) begin
                            state_next = DONE;
                            rd_next    = rs1_i;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    data_next  = stepped;
                    count_next = count_reg - step_amt;
                    if (count_reg == step_amt) begin
                        state_next = DONE;
                        rd_next    = stepped;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            rd_reg    <= '0;
            count_reg <= '0;
            op_reg    <= OP_SLL;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rd_reg    <= rd_next;
            count_reg <= count_next;
            op_reg    <= op_next;
        end
    end

    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == DONE);
    assign busy_o      = (state_reg != IDLE);
    assign rd_o        = rd_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; expected latencies follow SHIFTSEQ_STEP4_EN.
module tb_shift_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        kill_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rd_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_sequencer #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .kill_i      (kill_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rd_o        (rd_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int exp_lat(input int shamt);
`ifdef SHIFTSEQ_STEP4_EN
        return shamt / 4 + shamt % 4 + 1;
`else
        return shamt + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for rsp_valid_o; returns cycles counted from the accept cycle (cycle 0).
    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid_o && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp_rd, input int shamt);
        int n;
        check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        rs1_i = a;
        rs2_i = b;
        op_i  = op;
        step();
        req_valid_i = 1'b0;
        rs1_i = 32'h0;
        rs2_i = 32'h0;
        wait_rsp(n);
        check({tag, "_lat"}, n, exp_lat(shamt));
        check({tag, "_rd"}, rd_o, exp_rd);
        $display("txn %s: rs1=0x%08h rs2=0x%08h op=%0d rd=0x%08h lat=%0d", tag, a, b, op, rd_o, n);
    endtask

    task automatic drain(input string tag);
        rsp_ready_i = 1'b1;
        step();
        check({tag, "_idle"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int n;
        logic seen;
        logic [31:0] held;
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        op_i = 2'b00;
        rs1_i = 32'h0;
        rs2_i = 32'h0;
        kill_i = 1'b0;
        rsp_ready_i = 1'b1;

        repeat (2) step();
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o},      32'd0);
        check("rst_rd",    rd_o,                 32'h0);
        rst_i = 1'b0;
        step();

        // SLL by 31 with a stalled consumer.
        rsp_ready_i = 1'b0;
        run_op("sll31", 32'h0000_0001, 32'd31, 2'b00, 32'h8000_0000, 31);
        held = rd_o;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("hold_rd", rd_o, held);
        end
        drain("sll31");

        run_op("sra4", 32'h8000_00F0, 32'd4, 2'b10, 32'hF800_000F, 4);
        drain("sra4");
        run_op("srl4", 32'h8000_00F0, 32'd4, 2'b01, 32'h0800_000F, 4);
        drain("srl4");
        run_op("sra31neg", 32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF, 31);
        drain("sra31neg");
        run_op("sra28pos", 32'h7000_0000, 32'd28, 2'b10, 32'h0000_0007, 28);
        drain("sra28pos");
        run_op("rsvd_op", 32'h0000_0001, 32'd4, 2'b11, 32'h0000_0010, 4);
        drain("rsvd_op");
        run_op("shamt0", 32'hDEAD_BEEF, 32'h0000_0020, 2'b00, 32'hDEAD_BEEF, 0);
        drain("shamt0");
        run_op("mask3", 32'h0000_0001, 32'hFFFF_FFE3, 2'b00, 32'h0000_0008, 3);
        drain("mask3");

        // Request held valid through BUSY with different operands.
        req_valid_i = 1'b1;
        rs1_i = 32'h0000_00FF;
        rs2_i = 32'd8;
        op_i  = 2'b00;
        step();
        rs1_i = 32'h0000_0005;
        rs2_i = 32'd2;
        check("held_busy",  {31'd0, busy_o},      32'd1);
        check("held_noacc", {31'd0, req_ready_o}, 32'd0);
        wait_rsp(n);
        check("held_a_lat", n, exp_lat(8));
        check("held_a_rd",  rd_o, 32'h0000_FF00);
        $display("txn held_a: rd=0x%08h lat=%0d", rd_o, n);
        step();
        check("held_reidle", {31'd0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        check("held_b_busy", {31'd0, busy_o}, 32'd1);
        wait_rsp(n);
        check("held_b_lat", n, exp_lat(2));
        check("held_b_rd",  rd_o, 32'h0000_0014);
        $display("txn held_b: rd=0x%08h lat=%0d", rd_o, n);
        drain("held_b");

        // Kill in cycle 3 of a 20-bit shift.
        req_valid_i = 1'b1;
        rs1_i = 32'h0000_0001;
        rs2_i = 32'd20;
        op_i  = 2'b00;
        step();
        req_valid_i = 1'b0;
        step();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check("kill_ready", {31'd0, req_ready_o}, 32'd1);
        check("kill_busy",  {31'd0, busy_o},      32'd0);
        check("kill_valid", {31'd0, rsp_valid_o}, 32'd0);
        // A request alongside kill in IDLE is refused.
        kill_i = 1'b1;
        req_valid_i = 1'b1;
        rs2_i = 32'd0;
        step();
        kill_i = 1'b0;
        req_valid_i = 1'b0;
        check("kill_noacc_busy",  {31'd0, busy_o},      32'd0);
        check("kill_noacc_valid", {31'd0, rsp_valid_o}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (rsp_valid_o) seen = 1'b1;
        end
        check("kill_never_valid", {31'd0, seen}, 32'd0);
        $display("txn kill: aborted 20-bit shift, no response");
        run_op("post_kill", 32'h0000_0003, 32'd1, 2'b00, 32'h0000_0006, 1);
        drain("post_kill");

        // Reset during BUSY.
        req_valid_i = 1'b1;
        rs1_i = 32'h1234_5678;
        rs2_i = 32'd10;
        op_i  = 2'b01;
        step();
        req_valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_ready", {31'd0, req_ready_o}, 32'd1);
        check("midrst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("midrst_busy",  {31'd0, busy_o},      32'd0);
        check("midrst_rd",    rd_o,                 32'h0);
        $display("txn midrst: reset during BUSY");
        run_op("post_rst", 32'h0000_0001, 32'd31, 2'b00, 32'h8000_0000, 31);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
